// File: rtl/riscv_bp_pkg.sv
// riscv_bp_pkg
//   Shared definitions for the IF-stage branch predictor: branch-kind
//   encodings as resolved in ID, the canonical NOP, and the BTB index/tag
//   slicing helpers so every user splits a PC the same way.
package riscv_bp_pkg;

    typedef enum logic [1:0] {
        BP_COND = 2'b00,   // conditional branch
        BP_JAL  = 2'b01,   // plain jal
        BP_CALL = 2'b10,   // jal with rd = x1
        BP_RET  = 2'b11    // jalr x0, 0(x1)
    } bp_kind_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // Word-aligned index: pc[idxw+1:2]. Caller truncates to its index width.
    function automatic logic [63:0] bp_index(input logic [63:0] pc, input int unsigned idxw);
        return (pc >> 2) & ((64'd1 << idxw) - 64'd1);
    endfunction

    // Tag: everything above the index bits. Caller truncates to its tag width.
    function automatic logic [63:0] bp_tag(input logic [63:0] pc, input int unsigned idxw);
        return pc >> (idxw + 2);
    endfunction

endpackage

// File: rtl/bp_ras.sv
// bp_ras
//   Circular return address stack. A push when full overwrites the oldest
//   entry and the count stays at DEPTH. The caller only asserts pop_i when
//   count_o is non-zero; push and pop are never asserted together.
// Ports:
//   clk, rst      clock, synchronous active-high reset (pointer and count)
//   push_i        push push_data_i
//   pop_i         discard the top entry
//   push_data_i   return address to push
//   top_o         most recently pushed live entry
//   empty_o       no live entries
//   count_o       number of live entries, 0..DEPTH
module bp_ras #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned W     = 32,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  push_data_i,
    output logic [W-1:0]  top_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  stack_q [DEPTH];
    logic [PW-1:0] sp_q, sp_d;          // next free slot
    logic [PW-1:0] sp_inc, sp_dec;
    logic [CW-1:0] count_q, count_d;

    // Explicit wrap so a non power-of-two DEPTH still cycles correctly.
    assign sp_inc = (sp_q == PW'(DEPTH - 1)) ? '0 : sp_q + PW'(1);
    assign sp_dec = (sp_q == '0) ? PW'(DEPTH - 1) : sp_q - PW'(1);

    always_comb begin
        sp_d    = sp_q;
        count_d = count_q;
        if (push_i) begin
            sp_d    = sp_inc;
            count_d = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
        end else if (pop_i) begin
            sp_d    = sp_dec;
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q    <= '0;
            count_q <= '0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
            if (push_i) stack_q[sp_q] <= push_data_i;
        end
    end

    assign top_o   = stack_q[sp_dec];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor
//   BTB with per-entry saturating direction counters, branch-kind tags and an
//   optional return address stack. Lookup is combinational on the fetch PC;
//   training happens at the edge with the outcome resolved in ID.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   lookup_pc_i          fetch PC to predict
//   pred_hit_o           valid entry with matching tag
//   pred_taken_o         predicted taken
//   pred_next_pc_o       predicted next fetch PC
//   upd_valid_i          one resolved control-flow instruction this cycle
//   upd_pc_i             PC of the resolved instruction
//   upd_kind_i           bp_kind_e of the resolved instruction
//   upd_taken_i          actual direction
//   upd_target_i         actual taken target
//   upd_mispredict_i     IF/ID flush this cycle
//   mispredict_cnt_o     saturating count of flush cycles
module branch_predictor
    import riscv_bp_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ENTRIES   = 16,
    parameter int unsigned CTR_BITS  = 2,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc_i,
    output logic            pred_hit_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_next_pc_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic [1:0]      upd_kind_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i,
    input  logic            upd_mispredict_i,
    output logic [31:0]     mispredict_cnt_o
);
    localparam int unsigned IDXW   = $clog2(ENTRIES);
    localparam int unsigned TAGW   = XLEN - IDXW - 2;
    localparam int unsigned RAS_CW = (RAS_DEPTH > 0) ? $clog2(RAS_DEPTH + 1) : 1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

    function automatic logic [CTR_BITS-1:0] ctr_next(input logic [CTR_BITS-1:0] c,
                                                     input logic                up);
        if (up)  return (c == '1) ? c : c + CTR_BITS'(1);
        else     return (c == '0) ? c : c - CTR_BITS'(1);
    endfunction

    // Flop arrays so reset can clear every valid bit and counter at once.
    logic                valid_q [ENTRIES];
    logic [TAGW-1:0]     tag_q   [ENTRIES];
    logic [XLEN-1:0]     tgt_q   [ENTRIES];
    bp_kind_e            kind_q  [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q   [ENTRIES];
    logic [31:0]         mcnt_q, mcnt_d;

    logic [IDXW-1:0]   lk_idx, up_idx;
    logic [TAGW-1:0]   lk_tag, up_tag;
    logic              up_hit;
    logic [XLEN-1:0]   lk_tgt;
    logic [XLEN-1:0]   ras_top;
    logic              ras_empty;
    logic [RAS_CW-1:0] ras_count;
    logic              ras_push, ras_pop;

    assign lk_idx = IDXW'(bp_index(64'(lookup_pc_i), IDXW));
    assign lk_tag = TAGW'(bp_tag(64'(lookup_pc_i), IDXW));
    assign up_idx = IDXW'(bp_index(64'(upd_pc_i), IDXW));
    assign up_tag = TAGW'(bp_tag(64'(upd_pc_i), IDXW));
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Lookup
    assign pred_hit_o   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken_o = pred_hit_o &&
                          ((kind_q[lk_idx] != BP_COND) || ctr_q[lk_idx][CTR_BITS-1]);
    assign lk_tgt       = ((kind_q[lk_idx] == BP_RET) && !ras_empty) ? ras_top
                                                                     : tgt_q[lk_idx];
    assign pred_next_pc_o = pred_taken_o ? lk_tgt : lookup_pc_i + XLEN'(4);

    // RAS moves only on resolved calls/returns; a pop on empty is suppressed here.
    assign ras_push = upd_valid_i && (upd_kind_i == BP_CALL);
    assign ras_pop  = upd_valid_i && (upd_kind_i == BP_RET) && (ras_count != '0);

    if (RAS_DEPTH > 0) begin : g_ras
        bp_ras #(
            .DEPTH (RAS_DEPTH),
            .W     (XLEN)
        ) u_ras (
            .clk         (clk),
            .rst         (rst),
            .push_i      (ras_push),
            .pop_i       (ras_pop),
            .push_data_i (upd_pc_i + XLEN'(4)),
            .top_o       (ras_top),
            .empty_o     (ras_empty),
            .count_o     (ras_count)
        );
    end else begin : g_no_ras
        assign ras_top   = '0;
        assign ras_empty = 1'b1;
        assign ras_count = '0;
    end

    assign mcnt_d = (upd_mispredict_i && (mcnt_q != '1)) ? mcnt_q + 32'd1 : mcnt_q;

    // Training
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= '0;
            end
            mcnt_q <= '0;
        end else begin
            mcnt_q <= mcnt_d;
            if (upd_valid_i) begin
                if (up_hit) begin
                    if (upd_kind_i == BP_COND)
                        ctr_q[up_idx] <= ctr_next(ctr_q[up_idx], upd_taken_i);
                    kind_q[up_idx] <= bp_kind_e'(upd_kind_i);
                    if (upd_taken_i) tgt_q[up_idx] <= upd_target_i;
                end else if (upd_taken_i) begin
                    valid_q[up_idx] <= 1'b1;
                    tag_q[up_idx]   <= up_tag;
                    tgt_q[up_idx]   <= upd_target_i;
                    kind_q[up_idx]  <= bp_kind_e'(upd_kind_i);
                    ctr_q[up_idx]   <= CTR_WEAK;
                end
            end
        end
    end

    assign mispredict_cnt_o = mcnt_q;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch predictor that replaces the fixed 16-entry, single-bit BTB in the 5-stage RISC-V core. Sits beside the IF stage: looks up the fetch PC combinationally and supplies a predicted next PC. Trains from the resolved outcome in ID. Adds configurable depth, N-bit saturating direction counters, branch-kind tagging, a return address stack (RAS) for `jalr x0,0(x1)`, and a saturating mispredict counter.

## Interface
Parameters:
- `XLEN`, 32: address width.
- `ENTRIES`, 16: BTB entries; power of two, ≥2. `IDXW = log2(ENTRIES)`.
- `CTR_BITS`, 2: direction counter width, 1..3.
- `RAS_DEPTH`, 4: return stack depth; 0 removes the RAS.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `lookup_pc_i` in XLEN: current fetch PC.
- `pred_hit_o` out 1: tag hit on a valid entry.
- `pred_taken_o` out 1: predicted taken.
- `pred_next_pc_o` out XLEN: predicted next fetch PC.
- `upd_valid_i` in 1: one resolved control-flow instruction this cycle. The core qualifies it with not-stalled, so it pulses once per instruction.
- `upd_pc_i` in XLEN: PC of the resolved instruction.
- `upd_kind_i` in 2: kind of the resolved instruction. 00 = conditional branch, 01 = jal, 10 = call (jal with rd=x1), 11 = return.
- `upd_taken_i` in 1: actual direction.
- `upd_target_i` in XLEN: actual taken target.
- `upd_mispredict_i` in 1: core is flushing IF/ID this cycle.
- `mispredict_cnt_o` out 32: saturating count of mispredict cycles.

## Operation
- Index and tag:
  - index = pc[IDXW+1:2].
  - tag = pc[XLEN-1:IDXW+2].
- Each entry holds: valid, tag, target, kind, and a CTR_BITS counter.
- Lookup (combinational):
  - hit = valid && tag equal.
  - taken = hit && (kind≠00 || ctr[CTR_BITS-1]).
  - next PC = taken ? tgt : lookup_pc_i+4.
  - tgt = RAS top if kind=11 and RAS non-empty, else the stored target.
- Update, on a clock edge with `upd_valid_i`=1:
  - Hit at the upd index: conditional kind adjusts the counter, +1 if taken and −1 if not, saturating at 0 and 2^CTR_BITS−1. Kind is overwritten. Target is overwritten only when taken.
  - Miss and taken: allocate, overwriting any prior occupant. Set valid=1, tag, target, kind. Counter = 2^(CTR_BITS-1) (weakly taken).
  - Miss and not taken: no allocation.
- RAS, updated at resolve time only (never speculatively), in the same cycle as an update:
  - Call (10): push upd_pc_i+4. When full, overwrite the oldest entry (circular); count saturates at RAS_DEPTH.
  - Return (11): pop if count>0; no change if empty.
  - Other kinds: no RAS change.
  - RAS_DEPTH=0: returns use the stored target.
- `mispredict_cnt_o` increments on every cycle with `upd_mispredict_i`=1, saturating at 2^32−1. It is independent of `upd_valid_i`.

## Timing
- Lookup has zero-cycle latency. Outputs depend only on `lookup_pc_i` and state.
- Updates become visible on the cycle after the edge. A lookup and an update to the same index in the same cycle returns the pre-update contents.
- Reset (synchronous, `rst`=1 at an edge):
  - All valid bits, counters, RAS pointer and count, and `mispredict_cnt_o` are cleared.
  - The cycle after reset gives `pred_hit_o`=0, `pred_taken_o`=0, `pred_next_pc_o`=lookup_pc_i+4, `mispredict_cnt_o`=0.
- Reset has priority over a simultaneous update or mispredict; the state is cleared and the update is lost.
- RAS push/pop and entry write commit on the same edge.

## Structure
- Shared package `riscv_bp_pkg`:
  - kind encodings `BP_COND`, `BP_JAL`, `BP_CALL`, `BP_RET`.
  - `NOP` (32'h00000013).
  - index/tag slicing helper functions.
- Sub-module `bp_ras` (parameter DEPTH): circular stack with push, pop, top, empty, and count. It is not generated when RAS_DEPTH=0.
- Entry storage is flop arrays, not inferred RAM, because reset must clear every valid bit.

## Test plan
- Reset, then lookup 0x100: `pred_hit_o`=0, `pred_next_pc_o`=0x104, `mispredict_cnt_o`=0.
- Defaults, counter training:
  - Update cond 0x40 taken→0x80. Next cycle, lookup 0x40 gives hit, taken, next PC 0x80.
  - Two not-taken updates: counter reaches 0, prediction 0x44.
  - Three taken updates: counter saturates at 3; one not-taken update still predicts taken.
- Index aliasing, ENTRIES=16: 0x40 allocated, then taken update at 0x80 (same index, different tag) replaces it. Lookup 0x40 then misses, next PC 0x44.
- RAS with RAS_DEPTH=4:
  - Calls at 0x10, 0x20, 0x30, 0x50, 0x60 (five pushes; the 0x14 return address is overwritten).
  - Returns pop 0x64, 0x54, 0x34, 0x24, then stop: a fifth return leaves the RAS empty, and its lookup uses the stored target.
- Same-cycle lookup/update of 0x40: lookup returns old data that cycle and new data the next.
- `upd_mispredict_i` held for 5 cycles, then `rst`: counter reads 5, then 0 the cycle after reset.
